plat_scan_ctrl: RTL and testbench
=================================

PLAT_SCAN_CTRL -- requirements
Module: plat_scan_ctrl

Interface
REQ-001 SHALL have parameter PLATFORM_NUM_PER_BLOCK, default 7, platforms per block.
REQ-002 SHALL have parameter PHY_WIDTH, default 14, coordinate width.
REQ-003 SHALL have parameter BLOCK_LEN_WIDTH, default 4, platform length field width in tiles.
REQ-004 SHALL have parameters TILE_W, default 16, pixels per length unit; CHAR_W, default 16, character width; LAND_TOL, default 4, landing tolerance in pixels.
REQ-005 sys_clk  in  1  single clock, all logic rising-edge.
REQ-006 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 frame_tick  in  1  one-cycle scan start request.
REQ-008 block_switch  in  1  block changed; platform table is stale.
REQ-009 plat_relative_x / plat_relative_y  in  PLATFORM_NUM_PER_BLOCK*PHY_WIDTH  packed platform coordinates, index i at [i*PHY_WIDTH +: PHY_WIDTH].
REQ-010 plat_len  in  PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH  packed platform lengths.
REQ-011 char_x, char_foot_y  in  PHY_WIDTH  unsigned block-relative character left edge and foot position.
REQ-012 scan_valid  out  1; scan_ready  in  1; scan_idx  out  3; scan_x, scan_y  out  PHY_WIDTH; scan_len  out  BLOCK_LEN_WIDTH: serial platform stream.
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); land_hit  out  1; land_idx  out  3; land_y  out  PHY_WIDTH.

Function
REQ-014 SHALL implement states IDLE, LATCH, SCAN, DONE.
REQ-015 IDLE + frame_tick -> LATCH; LATCH lasts exactly one cycle, snapshots all three platform vectors into internal registers, clears idx and hit accumulator, -> SCAN.
REQ-016 In SCAN, scan_valid=1 and scan_x/y/len/idx SHALL present snapshot entry idx; transfer occurs on scan_valid && scan_ready.
REQ-017 scan_ready low SHALL hold all scan_* outputs stable; idx advances only on transfer.
REQ-018 On each transfer the entry SHALL be tested: hit iff char_x+CHAR_W > x AND char_x < x+len*TILE_W AND y <= char_foot_y <= y+LAND_TOL; sums computed PHY_WIDTH+BLOCK_LEN_WIDTH+1 bits wide, no wrap.
REQ-019 len=0 SHALL never hit but SHALL still be transferred.
REQ-020 Accumulator SHALL keep the lowest-index hit; later hits do not overwrite it.
REQ-021 Transfer of index PLATFORM_NUM_PER_BLOCK-1 -> DONE; DONE lasts one cycle, done=1, land_hit/land_idx/land_y updated from accumulator, -> IDLE.
REQ-022 land_* SHALL hold between done pulses; land_idx/land_y are 0 when land_hit=0.
REQ-023 busy=1 in LATCH, SCAN, DONE.
REQ-024 frame_tick while busy SHALL be ignored (no queueing).
REQ-025 block_switch in LATCH or SCAN SHALL abort to LATCH (re-snapshot, idx 0), no done pulse, land_* unchanged; in DONE it is ignored; in IDLE ignored.
REQ-026 frame_tick and block_switch together in IDLE SHALL start a scan normally.
REQ-027 Minimum start-to-done latency with scan_ready held high: 1 (LATCH) + PLATFORM_NUM_PER_BLOCK (SCAN) cycles, done in the following cycle (9 cycles after frame_tick for default).

Reset
REQ-028 sys_rst_n low SHALL asynchronously force IDLE, snapshot and accumulator to 0, all outputs to 0.
REQ-029 Reset mid-scan SHALL discard the scan; no done pulse after release until a new frame_tick.

Configuration
REQ-030 Macro PLAT_SCAN_EARLY_EXIT_EN defined: transfer of the first hitting entry SHALL go directly to DONE (remaining entries not issued).
REQ-031 Macro undefined: all PLATFORM_NUM_PER_BLOCK entries always issued; result identical (lowest-index hit), latency fixed.

Structure
REQ-032 PLATFORM_NUM_PER_BLOCK, PHY_WIDTH, BLOCK_LEN_WIDTH, TILE_W, CHAR_W, state encoding SHALL live in shared package jk_game_pkg.
REQ-033 Hit test SHALL be sub-module plat_hit_test (combinational, one entry plus character in, hit out).

Verification
REQ-034 Entry0 x=250,y=60,len=10; char_x=260, foot=62; frame_tick, ready=1 -> done 9 cycles later, land_hit=1, land_idx=0, land_y=60.
REQ-035 Entry1 x=100,y=80,len=8 and entry3 x=100,y=80,len=8; char_x=110, foot=80 -> land_idx=1; with EARLY_EXIT_EN done 4 cycles after frame_tick.
REQ-036 char_x=0, foot=500, all entries miss -> land_hit=0, land_idx=0, land_y=0.
REQ-037 scan_ready toggled 1/0 each cycle -> scan_* stable while low, done 16 cycles after frame_tick, idx sequence 0..6 without gaps.
REQ-038 block_switch at SCAN idx=3 with new table -> restart at idx 0, single done reflecting new table only; frame_tick during SCAN ignored.
REQ-039 sys_rst_n low at idx=4 -> all outputs 0 immediately, no done after release.

Source files
------------

// File: rtl/jk_game_pkg.sv
// Shared platform/character geometry defaults and scan controller state encoding.
package jk_game_pkg;

    localparam int unsigned PLATFORM_NUM_PER_BLOCK = 7;
    localparam int unsigned PHY_WIDTH              = 14;
    localparam int unsigned BLOCK_LEN_WIDTH        = 4;
    localparam int unsigned TILE_W                 = 16;
    localparam int unsigned CHAR_W                 = 16;
    localparam int unsigned LAND_TOL               = 4;
    localparam int unsigned SCAN_IDX_W             = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/plat_hit_test.sv
// Combinational landing test of the character against one platform entry.
module plat_hit_test #(
    parameter int unsigned PHY_WIDTH       = jk_game_pkg::PHY_WIDTH,
    parameter int unsigned BLOCK_LEN_WIDTH = jk_game_pkg::BLOCK_LEN_WIDTH,
    parameter int unsigned TILE_W          = jk_game_pkg::TILE_W,
    parameter int unsigned CHAR_W          = jk_game_pkg::CHAR_W,
    parameter int unsigned LAND_TOL        = jk_game_pkg::LAND_TOL
) (
    input  logic [PHY_WIDTH-1:0]       plat_x,
    input  logic [PHY_WIDTH-1:0]       plat_y,
    input  logic [BLOCK_LEN_WIDTH-1:0] plat_len,
    input  logic [PHY_WIDTH-1:0]       char_x,
    input  logic [PHY_WIDTH-1:0]       char_foot_y,
    output logic                       hit_c
);

    // Extra headroom so right edges and tolerance window never wrap.
    localparam int unsigned SUM_W = PHY_WIDTH + BLOCK_LEN_WIDTH + 1;

    logic [SUM_W-1:0] char_right;
    logic [SUM_W-1:0] plat_right;
    logic [SUM_W-1:0] land_bottom;

    always_comb begin
        char_right  = SUM_W'(char_x) + SUM_W'(CHAR_W);
        plat_right  = SUM_W'(plat_x) + SUM_W'(plat_len) * SUM_W'(TILE_W);
        land_bottom = SUM_W'(plat_y) + SUM_W'(LAND_TOL);
        hit_c = (plat_len != '0)
             && (char_right > SUM_W'(plat_x))
             && (SUM_W'(char_x) < plat_right)
             && (char_foot_y >= plat_y)
             && (SUM_W'(char_foot_y) <= land_bottom);
    end

endmodule

// File: rtl/plat_scan_ctrl.sv
// Snapshots a block's platform table, streams it out serially and reports the lowest-index landing hit.
// PLAT_SCAN_EARLY_EXIT_EN: finish the scan on the first hitting entry.
module plat_scan_ctrl #(
    parameter int unsigned PLATFORM_NUM_PER_BLOCK = jk_game_pkg::PLATFORM_NUM_PER_BLOCK,
    parameter int unsigned PHY_WIDTH              = jk_game_pkg::PHY_WIDTH,
    parameter int unsigned BLOCK_LEN_WIDTH        = jk_game_pkg::BLOCK_LEN_WIDTH,
    parameter int unsigned TILE_W                 = jk_game_pkg::TILE_W,
    parameter int unsigned CHAR_W                 = jk_game_pkg::CHAR_W,
    parameter int unsigned LAND_TOL               = jk_game_pkg::LAND_TOL
) (
    input  logic                                              sys_clk,
    input  logic                                              sys_rst_n,
    input  logic                                              frame_tick,
    input  logic                                              block_switch,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_x,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_y,
    input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
    input  logic [PHY_WIDTH-1:0]                              char_x,
    input  logic [PHY_WIDTH-1:0]                              char_foot_y,
    output logic                                              scan_valid,
    input  logic                                              scan_ready,
    output logic [2:0]                                        scan_idx,
    output logic [PHY_WIDTH-1:0]                              scan_x,
    output logic [PHY_WIDTH-1:0]                              scan_y,
    output logic [BLOCK_LEN_WIDTH-1:0]                        scan_len,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              land_hit,
    output logic [2:0]                                        land_idx,
    output logic [PHY_WIDTH-1:0]                              land_y
);

    import jk_game_pkg::scan_state_e;
    import jk_game_pkg::ST_IDLE;
    import jk_game_pkg::ST_LATCH;
    import jk_game_pkg::ST_SCAN;
    import jk_game_pkg::ST_DONE;

    localparam int unsigned IDX_W = jk_game_pkg::SCAN_IDX_W;
    localparam int unsigned XY_W  = PLATFORM_NUM_PER_BLOCK * PHY_WIDTH;
    localparam int unsigned LEN_W = PLATFORM_NUM_PER_BLOCK * BLOCK_LEN_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PLATFORM_NUM_PER_BLOCK - 1);

    scan_state_e state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [XY_W-1:0]            snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [LEN_W-1:0]           snap_len_q, snap_len_d;
    logic                       acc_hit_q, acc_hit_d;
    logic [IDX_W-1:0]           acc_idx_q, acc_idx_d;
    logic [PHY_WIDTH-1:0]       acc_y_q, acc_y_d;
    logic                       scan_valid_q, scan_valid_d;
    logic [IDX_W-1:0]           scan_idx_q, scan_idx_d;
    logic [PHY_WIDTH-1:0]       scan_x_q, scan_x_d, scan_y_q, scan_y_d;
    logic [BLOCK_LEN_WIDTH-1:0] scan_len_q, scan_len_d;
    logic                       busy_q, busy_d, done_q, done_d;
    logic                       land_hit_q, land_hit_d;
    logic [IDX_W-1:0]           land_idx_q, land_idx_d;
    logic [PHY_WIDTH-1:0]       land_y_q, land_y_d;
    logic                       hit_c, xfer_c, stop_c;

    // The presented entry is exactly the one under test on a transfer.
    plat_hit_test #(
        .PHY_WIDTH      (PHY_WIDTH),
        .BLOCK_LEN_WIDTH(BLOCK_LEN_WIDTH),
        .TILE_W         (TILE_W),
        .CHAR_W         (CHAR_W),
        .LAND_TOL       (LAND_TOL)
    ) u_hit (
        .plat_x     (scan_x_q),
        .plat_y     (scan_y_q),
        .plat_len   (scan_len_q),
        .char_x     (char_x),
        .char_foot_y(char_foot_y),
        .hit_c      (hit_c)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_x_d   = snap_x_q;
        snap_y_d   = snap_y_q;
        snap_len_d = snap_len_q;
        acc_hit_d  = acc_hit_q;
        acc_idx_d  = acc_idx_q;
        acc_y_d    = acc_y_q;
        land_hit_d = land_hit_q;
        land_idx_d = land_idx_q;
        land_y_d   = land_y_q;
        done_d     = 1'b0;
        scan_idx_d = '0;
        scan_x_d   = '0;
        scan_y_d   = '0;
        scan_len_d = '0;
        xfer_c     = scan_valid_q && scan_ready;
`ifdef PLAT_SCAN_EARLY_EXIT_EN
        stop_c     = (idx_q == LAST_IDX) || hit_c;
`else
        stop_c     = (idx_q == LAST_IDX);
`endif

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                snap_x_d   = plat_relative_x;
                snap_y_d   = plat_relative_y;
                snap_len_d = plat_len;
                idx_d      = '0;
                acc_hit_d  = 1'b0;
                acc_idx_d  = '0;
                acc_y_d    = '0;
                if (!block_switch) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (block_switch) begin
                    state_d = ST_LATCH;
                    idx_d   = '0;
                end else if (xfer_c) begin
                    if (hit_c && !acc_hit_q) begin
                        acc_hit_d = 1'b1;
                        acc_idx_d = idx_q;
                        acc_y_d   = scan_y_q;
                    end
                    if (stop_c) state_d = ST_DONE;
                    else        idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Results publish together with the done pulse.
        if (state_d == ST_DONE) begin
            done_d     = 1'b1;
            land_hit_d = acc_hit_d;
            land_idx_d = acc_idx_d;
            land_y_d   = acc_y_d;
        end

        busy_d       = (state_d != ST_IDLE);
        scan_valid_d = (state_d == ST_SCAN);
        if (scan_valid_d) begin
            scan_idx_d = idx_d;
            for (int i = 0; i < int'(PLATFORM_NUM_PER_BLOCK); i++) begin
                if (idx_d == IDX_W'(i)) begin
                    scan_x_d   = snap_x_d[i*PHY_WIDTH +: PHY_WIDTH];
                    scan_y_d   = snap_y_d[i*PHY_WIDTH +: PHY_WIDTH];
                    scan_len_d = snap_len_d[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_len_q   <= '0;
            acc_hit_q    <= 1'b0;
            acc_idx_q    <= '0;
            acc_y_q      <= '0;
            scan_valid_q <= 1'b0;
            scan_idx_q   <= '0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            scan_len_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            land_hit_q   <= 1'b0;
            land_idx_q   <= '0;
            land_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            snap_len_q   <= snap_len_d;
            acc_hit_q    <= acc_hit_d;
            acc_idx_q    <= acc_idx_d;
            acc_y_q      <= acc_y_d;
            scan_valid_q <= scan_valid_d;
            scan_idx_q   <= scan_idx_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            scan_len_q   <= scan_len_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            land_hit_q   <= land_hit_d;
            land_idx_q   <= land_idx_d;
            land_y_q     <= land_y_d;
        end
    end

    assign scan_valid = scan_valid_q;
    assign scan_idx   = scan_idx_q;
    assign scan_x     = scan_x_q;
    assign scan_y     = scan_y_q;
    assign scan_len   = scan_len_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign land_hit   = land_hit_q;
    assign land_idx   = land_idx_q;
    assign land_y     = land_y_q;

endmodule

// File: tb/tb_plat_scan_ctrl.sv
// Directed bench for plat_scan_ctrl; expected latencies follow PLAT_SCAN_EARLY_EXIT_EN.
module tb_plat_scan_ctrl;

    localparam int unsigned N   = 7;
    localparam int unsigned PW  = 14;
    localparam int unsigned LW  = 4;

`ifdef PLAT_SCAN_EARLY_EXIT_EN
    localparam int LAT_T1 = 3;
    localparam int LAT_T2 = 4;
    localparam int LAT_T5 = 8;
    localparam int LAT_T6 = 13;
    localparam int XFER_T6 = 9;
`else
    localparam int LAT_T1 = 9;
    localparam int LAT_T2 = 9;
    localparam int LAT_T5 = 9;
    localparam int LAT_T6 = 14;
    localparam int XFER_T6 = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic frame_tick, block_switch, scan_ready;
    logic [N*PW-1:0] px, py, nx, ny;
    logic [N*LW-1:0] pl, nl;
    logic [PW-1:0]   char_x, char_foot_y;
    logic            scan_valid, busy, done, land_hit;
    logic [2:0]      scan_idx, land_idx;
    logic [PW-1:0]   scan_x, scan_y, land_y;
    logic [LW-1:0]   scan_len;

    int n_cmp = 0;
    int n_err = 0;
    int xfer_q[$];
    int stab_err;
    int first_x;
    int busy_c1;
    logic [2:0] idx_at_sw;

    always #5 clk = ~clk;

    plat_scan_ctrl dut (
        .sys_clk        (clk),
        .sys_rst_n      (rst_n),
        .frame_tick     (frame_tick),
        .block_switch   (block_switch),
        .plat_relative_x(px),
        .plat_relative_y(py),
        .plat_len       (pl),
        .char_x         (char_x),
        .char_foot_y    (char_foot_y),
        .scan_valid     (scan_valid),
        .scan_ready     (scan_ready),
        .scan_idx       (scan_idx),
        .scan_x         (scan_x),
        .scan_y         (scan_y),
        .scan_len       (scan_len),
        .busy           (busy),
        .done           (done),
        .land_hit       (land_hit),
        .land_idx       (land_idx),
        .land_y         (land_y)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_entry(input bit nxt, input int i, input int x, input int y, input int len);
        if (nxt) begin
            nx[i*PW +: PW] = PW'(x);
            ny[i*PW +: PW] = PW'(y);
            nl[i*LW +: LW] = LW'(len);
        end else begin
            px[i*PW +: PW] = PW'(x);
            py[i*PW +: PW] = PW'(y);
            pl[i*LW +: LW] = LW'(len);
        end
    endtask

    task automatic clear_tables();
        px = '0; py = '0; pl = '0;
        nx = '0; ny = '0; nl = '0;
    endtask

    // Cycle 0 carries frame_tick; cycle k is the k-th clock period after it.
    task automatic run_frame(input bit toggle, input int sw_cyc, input int tick_cyc,
                             input int ncyc, output int first_done, output int n_done);
        logic       held_v;
        logic [2:0] h_idx;
        logic [PW-1:0] h_x, h_y;
        logic [LW-1:0] h_len;
        xfer_q.delete();
        first_done = -1;
        n_done     = 0;
        stab_err   = 0;
        first_x    = -1;
        busy_c1    = -1;
        held_v     = 1'b0;
        h_idx = '0; h_x = '0; h_y = '0; h_len = '0;
        @(negedge clk);
        frame_tick = 1'b1;
        scan_ready = 1'b1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk);
            #1;
            if (held_v && (scan_idx !== h_idx || scan_x !== h_x || scan_y !== h_y || scan_len !== h_len))
                stab_err++;
            if (cyc == 1) busy_c1 = int'(busy);
            frame_tick   = (cyc == tick_cyc);
            scan_ready   = toggle ? (cyc % 2 == 1) : 1'b1;
            block_switch = (cyc == sw_cyc);
            if (cyc == sw_cyc) begin
                idx_at_sw = scan_idx;
                px = nx; py = ny; pl = nl;
            end
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = cyc;
            end
            if (scan_valid && scan_ready && !block_switch) begin
                xfer_q.push_back(int'(scan_idx));
                if (first_x < 0) first_x = int'(scan_x);
            end
            held_v = scan_valid && !scan_ready;
            h_idx = scan_idx; h_x = scan_x; h_y = scan_y; h_len = scan_len;
        end
        frame_tick   = 1'b0;
        block_switch = 1'b0;
        scan_ready   = 1'b1;
    endtask

    initial begin
        int lat, nd, bad;
        rst_n = 1'b0;
        frame_tick = 1'b0; block_switch = 1'b0; scan_ready = 1'b1;
        char_x = '0; char_foot_y = '0;
        idx_at_sw = '0;
        clear_tables();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_valid", 32'(scan_valid), 32'd0);
        check_eq("rst_land_hit", 32'(land_hit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single hit on entry 0.
        clear_tables();
        set_entry(0, 0, 250, 60, 10);
        char_x = 14'd260; char_foot_y = 14'd62;
        run_frame(1'b0, -1, -1, 30, lat, nd);
        check_eq("t1_latency", 32'(lat), 32'(LAT_T1));
        check_eq("t1_done_count", 32'(nd), 32'd1);
        check_eq("t1_busy_latch", 32'(busy_c1), 32'd1);
        check_eq("t1_land_hit", 32'(land_hit), 32'd1);
        check_eq("t1_land_idx", 32'(land_idx), 32'd0);
        check_eq("t1_land_y", 32'(land_y), 32'd60);
        check_eq("t1_first_x", 32'(first_x), 32'd250);
        check_eq("t1_busy_after", 32'(busy), 32'd0);

        // Two hits; lowest index wins.
        clear_tables();
        set_entry(0, 1, 100, 80, 8);
        set_entry(0, 3, 100, 80, 8);
        char_x = 14'd110; char_foot_y = 14'd80;
        run_frame(1'b0, -1, -1, 30, lat, nd);
        check_eq("t2_latency", 32'(lat), 32'(LAT_T2));
        check_eq("t2_land_hit", 32'(land_hit), 32'd1);
        check_eq("t2_land_idx", 32'(land_idx), 32'd1);
        check_eq("t2_land_y", 32'(land_y), 32'd80);

        // All miss: land fields return to zero.
        clear_tables();
        set_entry(0, 2, 300, 200, 5);
        set_entry(0, 4, 500, 400, 3);
        char_x = 14'd0; char_foot_y = 14'd500;
        run_frame(1'b0, -1, -1, 30, lat, nd);
        check_eq("t3_latency", 32'(lat), 32'd9);
        check_eq("t3_land_hit", 32'(land_hit), 32'd0);
        check_eq("t3_land_idx", 32'(land_idx), 32'd0);
        check_eq("t3_land_y", 32'(land_y), 32'd0);

        // Backpressure every other cycle.
        run_frame(1'b1, -1, -1, 30, lat, nd);
        check_eq("t4_latency", 32'(lat), 32'd16);
        check_eq("t4_done_count", 32'(nd), 32'd1);
        check_eq("t4_stable", 32'(stab_err), 32'd0);
        check_eq("t4_xfer_count", 32'(xfer_q.size()), 32'd7);
        bad = 0;
        foreach (xfer_q[i]) if (xfer_q[i] != i) bad++;
        check_eq("t4_idx_seq", 32'(bad), 32'd0);

        // Geometry edges: only entry 5 (and later 6) land.
        clear_tables();
        set_entry(0, 0, 300, 100, 2);
        set_entry(0, 1, 252, 100, 2);
        set_entry(0, 2, 280, 99, 1);
        set_entry(0, 3, 280, 105, 1);
        set_entry(0, 4, 280, 100, 0);
        set_entry(0, 5, 280, 100, 1);
        set_entry(0, 6, 281, 104, 1);
        char_x = 14'd284; char_foot_y = 14'd104;
        run_frame(1'b0, -1, -1, 30, lat, nd);
        check_eq("t5_latency", 32'(lat), 32'(LAT_T5));
        check_eq("t5_land_hit", 32'(land_hit), 32'd1);
        check_eq("t5_land_idx", 32'(land_idx), 32'd5);
        check_eq("t5_land_y", 32'(land_y), 32'd100);

        // Block switch at idx 3 restarts on the new table; stray frame_tick ignored.
        clear_tables();
        set_entry(0, 6, 250, 60, 10);
        set_entry(1, 5, 240, 58, 4);
        char_x = 14'd260; char_foot_y = 14'd62;
        run_frame(1'b0, 5, 3, 30, lat, nd);
        check_eq("t6_idx_at_switch", 32'(idx_at_sw), 32'd3);
        check_eq("t6_latency", 32'(lat), 32'(LAT_T6));
        check_eq("t6_done_count", 32'(nd), 32'd1);
        check_eq("t6_xfer_count", 32'(xfer_q.size()), 32'(XFER_T6));
        check_eq("t6_restart_idx", (xfer_q.size() > 3) ? 32'(xfer_q[3]) : 32'hFFFF_FFFF, 32'd0);
        check_eq("t6_land_idx", 32'(land_idx), 32'd5);
        check_eq("t6_land_y", 32'(land_y), 32'd58);

        // Reset mid-scan at idx 4.
        clear_tables();
        set_entry(0, 2, 300, 200, 5);
        set_entry(0, 4, 500, 400, 3);
        char_x = 14'd0; char_foot_y = 14'd500;
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("t7_idx_before", 32'(scan_idx), 32'd4);
        check_eq("t7_x_before", 32'(scan_x), 32'd500);
        rst_n = 1'b0;
        #1;
        check_eq("t7_valid", 32'(scan_valid), 32'd0);
        check_eq("t7_idx", 32'(scan_idx), 32'd0);
        check_eq("t7_x", 32'(scan_x), 32'd0);
        check_eq("t7_busy", 32'(busy), 32'd0);
        check_eq("t7_land_hit", 32'(land_hit), 32'd0);
        check_eq("t7_land_y", 32'(land_y), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) nd++;
        end
        check_eq("t7_no_done_after", 32'(nd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
